dma64_mem_bridge: RTL and testbench

- Memory-side DMA responder for the LeNet accelerator wrapper.
- Serves the accelerator's 64-bit read path (ctrl + chnl) and write path (ctrl + chnl) from a single-port, 64-bit-wide, 1-cycle-latency memory.
- Read data is buffered in a small FIFO so the block honours chnl backpressure at full throughput.
- Used as the system-memory model in simulation and as the bridge to a BRAM in FPGA builds.

---
 rtl/dma64_pkg.sv | 13 +
 rtl/sync_fifo_64.sv | 61 ++++++
 rtl/dma64_mem_bridge.sv | 140 ++++++++++++++
 tb/tb_dma64_mem_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma64_pkg.sv
// Shared types and constants for the 64-bit DMA memory bridge.
package dma64_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_RUN = 2'd1,
      WR_RUN = 2'd2
   } state_t;

   localparam int DMA_BEAT_W = 64;

   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [2:0] SIZE_DWORD = 3'b011;
endpackage

// File: rtl/sync_fifo_64.sv
// Shift-register FIFO with registered head; push/pop same cycle legal.
// Latency 1 cycle push-to-dout; pushes while full and not popping are dropped.
module sync_fifo_64
   import dma64_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = DMA_BEAT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] w_nxt [DEPTH];
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic [CW-1:0]    w_wr_idx;
   logic             r_empty;
   logic             w_pop;
   logic             w_push;

   assign w_pop       = pop & (r_count != '0);
   assign w_push      = push & ((r_count != CW'(DEPTH)) | w_pop);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   assign w_wr_idx    = r_count - CW'(w_pop);

   // Entry 0 is always the head, so dout comes straight from a flop.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) w_nxt[i] = r_mem[i];
      if (w_pop)
         for (int i = 0; i < DEPTH-1; i++) w_nxt[i] = r_mem[i+1];
      if (w_push)
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == w_wr_idx) w_nxt[i] = din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
      end else begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_nxt[i];
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign dout  = r_mem[0];
   assign count = r_count;
   assign empty = r_empty;
   assign full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/dma64_mem_bridge.sv
// DMA responder serving 64-bit read/write channels from a 1-cycle single-port memory.
// Read: first beat 2 cycles after ctrl handshake, 1 beat/cycle; chnl ready backpressure absorbed by the read FIFO.
module dma64_mem_bridge
   import dma64_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int RFIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dma_read_ctrl_valid,
   output logic              dma_read_ctrl_ready,
   input  logic [31:0]       dma_read_ctrl_data_index,
   input  logic [31:0]       dma_read_ctrl_data_length,
   input  logic [2:0]        dma_read_ctrl_data_size,
   output logic              dma_read_chnl_valid,
   output logic [63:0]       dma_read_chnl_data,
   input  logic              dma_read_chnl_ready,
   input  logic              dma_write_ctrl_valid,
   output logic              dma_write_ctrl_ready,
   input  logic [31:0]       dma_write_ctrl_data_index,
   input  logic [31:0]       dma_write_ctrl_data_length,
   input  logic [2:0]        dma_write_ctrl_data_size,
   input  logic              dma_write_chnl_valid,
   input  logic [63:0]       dma_write_chnl_data,
   output logic              dma_write_chnl_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);
   localparam int CW = $clog2(RFIFO_DEPTH+1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_len;
   logic [31:0]       r_issued;
   logic [31:0]       r_done;
   logic              r_inflight;
   logic [2:0]        r_size;

   logic              w_idle;
   logic              w_rd_hs;
   logic              w_wr_hs;
   logic              w_beat;
   logic              w_pop;
   logic              w_issue;
   logic [31:0]       w_len;
   logic [CW-1:0]     w_fifo_count;
   logic [CW:0]       w_occ;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_unused;

   assign w_idle               = (r_state == IDLE);
   assign dma_read_ctrl_ready  = rst & w_idle;
   assign dma_write_ctrl_ready = rst & w_idle & dma_write_ctrl_valid & ~dma_read_ctrl_valid;
   assign w_rd_hs              = dma_read_ctrl_valid & dma_read_ctrl_ready;
   assign w_wr_hs              = dma_write_ctrl_valid & dma_write_ctrl_ready;
   assign w_len                = w_rd_hs ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;

   assign dma_write_chnl_ready = rst & (r_state == WR_RUN);
   assign w_beat               = dma_write_chnl_valid & dma_write_chnl_ready;

   assign dma_read_chnl_valid  = ~w_fifo_empty;
   assign w_pop                = dma_read_chnl_valid & dma_read_chnl_ready;

   // Reserve a FIFO slot for every read still in the memory pipe.
   assign w_occ   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
   assign w_issue = rst & (r_state == RD_RUN) & (r_issued < r_len)
                  & (w_occ < (CW+1)'(RFIFO_DEPTH));

   assign mem_en    = w_issue | w_beat;
   assign mem_we    = w_beat;
   assign mem_addr  = w_beat  ? r_base + r_done[ADDR_W-1:0]   :
                      w_issue ? r_base + r_issued[ADDR_W-1:0] : '0;
   assign mem_wdata = w_beat ? dma_write_chnl_data : '0;
   assign busy      = ~w_idle;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_done     <= '0;
         r_inflight <= 1'b0;
         r_size     <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) r_issued <= r_issued + 32'd1;
         case (r_state)
            IDLE: begin
               if (w_rd_hs | w_wr_hs) begin
                  r_base   <= w_rd_hs ? dma_read_ctrl_data_index[ADDR_W-1:0]
                                      : dma_write_ctrl_data_index[ADDR_W-1:0];
                  r_size   <= w_rd_hs ? dma_read_ctrl_data_size : dma_write_ctrl_data_size;
                  r_len    <= w_len;
                  r_issued <= '0;
                  r_done   <= '0;
                  if (w_len != '0) r_state <= w_rd_hs ? RD_RUN : WR_RUN;
               end
            end
            RD_RUN: begin
               if (w_pop) begin
                  r_done <= r_done + 32'd1;
                  if (r_done == r_len - 32'd1) r_state <= IDLE;
               end
            end
            WR_RUN: begin
               if (w_beat) begin
                  r_done <= r_done + 32'd1;
                  if (r_done == r_len - 32'd1) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sync_fifo_64 #(
      .DEPTH (RFIFO_DEPTH),
      .WIDTH (DMA_BEAT_W)
   ) u_rfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_inflight),
      .pop   (w_pop),
      .din   (mem_rdata),
      .dout  (dma_read_chnl_data),
      .count (w_fifo_count),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

   // Size is carried for the accelerator's benefit only; upper index bits are don't-care.
   assign w_unused = ^{dma_read_ctrl_data_index, dma_write_ctrl_data_index, r_size, w_fifo_full};
endmodule

// File: tb/tb_dma64_mem_bridge.sv
// Bench for dma64_mem_bridge: memory model, expected-beat queues and directed/random traffic.
module tb_dma64_mem_bridge;
   import dma64_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dma_read_ctrl_valid = 1'b0;
   logic        dma_read_ctrl_ready;
   logic [31:0] dma_read_ctrl_data_index = '0;
   logic [31:0] dma_read_ctrl_data_length = '0;
   logic [2:0]  dma_read_ctrl_data_size = '0;
   logic        dma_read_chnl_valid;
   logic [63:0] dma_read_chnl_data;
   logic        dma_read_chnl_ready = 1'b1;
   logic        dma_write_ctrl_valid = 1'b0;
   logic        dma_write_ctrl_ready;
   logic [31:0] dma_write_ctrl_data_index = '0;
   logic [31:0] dma_write_ctrl_data_length = '0;
   logic [2:0]  dma_write_ctrl_data_size = '0;
   logic        dma_write_chnl_valid = 1'b0;
   logic [63:0] dma_write_chnl_data = '0;
   logic        dma_write_chnl_ready;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic        busy;

   logic [63:0] mem     [0:65535];
   logic [63:0] ref_mem [0:65535];
   logic [63:0] rd_exp [$];
   logic [15:0] wa_exp [$];
   logic [63:0] wd_exp [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_pop = 0;
   int          n_wr = 0;
   bit          rnd_rdy = 1'b0;
   bit          hold = 1'b0;
   logic [63:0] hold_dat = '0;

   always #5 clk = ~clk;

   dma64_mem_bridge #(.ADDR_W(16), .RFIFO_DEPTH(2)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .dma_read_ctrl_valid        (dma_read_ctrl_valid),
      .dma_read_ctrl_ready        (dma_read_ctrl_ready),
      .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
      .dma_read_chnl_valid        (dma_read_chnl_valid),
      .dma_read_chnl_data         (dma_read_chnl_data),
      .dma_read_chnl_ready        (dma_read_chnl_ready),
      .dma_write_ctrl_valid       (dma_write_ctrl_valid),
      .dma_write_ctrl_ready       (dma_write_ctrl_ready),
      .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
      .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
      .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
      .dma_write_chnl_valid       (dma_write_chnl_valid),
      .dma_write_chnl_data        (dma_write_chnl_data),
      .dma_write_chnl_ready       (dma_write_chnl_ready),
      .mem_en                     (mem_en),
      .mem_we                     (mem_we),
      .mem_addr                   (mem_addr),
      .mem_wdata                  (mem_wdata),
      .mem_rdata                  (mem_rdata),
      .busy                       (busy)
   );

   // Single-port memory, one cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Beat-level scoreboard: pops in order, writes in order, data held under backpressure.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("rd_hold_vld", dma_read_chnl_valid, 1'b1);
               chk("rd_hold_dat", dma_read_chnl_data, hold_dat);
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) begin
               chk("rd_expected", rd_exp.size() != 0, 1'b1);
               if (rd_exp.size() != 0) chk("rd_dat", dma_read_chnl_data, rd_exp.pop_front());
               n_pop++;
            end
            hold     = dma_read_chnl_valid & ~dma_read_chnl_ready;
            hold_dat = dma_read_chnl_data;
            if (mem_en && mem_we) begin
               chk("wr_expected", wa_exp.size() != 0, 1'b1);
               if (wa_exp.size() != 0) begin
                  chk("wr_addr", mem_addr, wa_exp.pop_front());
                  chk("wr_dat", mem_wdata, wd_exp.pop_front());
               end
               n_wr++;
            end
         end
      end
   end

   initial begin : rdy_driver
      forever begin
         @(posedge clk);
         #1;
         dma_read_chnl_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   task automatic rd_req(input logic [31:0] idx, input int len);
      bit ok = 1'b0;
      for (int i = 0; i < len; i++) rd_exp.push_back(ref_mem[16'(idx + 32'(i))]);
      dma_read_ctrl_valid       = 1'b1;
      dma_read_ctrl_data_index  = idx;
      dma_read_ctrl_data_length = 32'(len);
      dma_read_ctrl_data_size   = SIZE_DWORD;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (dma_read_ctrl_ready) begin ok = 1'b1; break; end
      end
      chk("rd_ctrl_hs", ok, 1'b1);
      cyc();
      dma_read_ctrl_valid = 1'b0;
   endtask

   task automatic wr_req(input logic [31:0] idx, input int len);
      bit ok = 1'b0;
      dma_write_ctrl_valid       = 1'b1;
      dma_write_ctrl_data_index  = idx;
      dma_write_ctrl_data_length = 32'(len);
      dma_write_ctrl_data_size   = SIZE_WORD;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (dma_write_ctrl_ready) begin ok = 1'b1; break; end
      end
      chk("wr_ctrl_hs", ok, 1'b1);
      cyc();
      dma_write_ctrl_valid = 1'b0;
   endtask

   task automatic wr_beats(input logic [31:0] idx, input int len, input int gap);
      logic [63:0] d;
      logic [15:0] a;
      for (int i = 0; i < len; i++) begin
         d = {$urandom, $urandom};
         a = 16'(idx + 32'(i));
         wa_exp.push_back(a);
         wd_exp.push_back(d);
         ref_mem[a] = d;
         dma_write_chnl_valid = 1'b1;
         dma_write_chnl_data  = d;
         @(negedge clk);
         chk("wr_chnl_rdy", dma_write_chnl_ready, 1'b1);
         cyc();
         dma_write_chnl_valid = 1'b0;
         repeat (gap) cyc();
      end
   endtask

   task automatic wait_idle(input int max, input string tag);
      bit ok = 1'b0;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         #1;
         if (!busy && rd_exp.size() == 0 && wa_exp.size() == 0) begin ok = 1'b1; break; end
      end
      chk(tag, ok, 1'b1);
      cyc();
   endtask

   initial begin : main
      int first, last, nv, p0, w0, bad, blocked;
      bit ok;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 64'(i);
         ref_mem[i] = 64'(i);
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_vld", dma_read_chnl_valid, 1'b0);
      chk("rst_rd_dat", dma_read_chnl_data, 64'd0);
      chk("rst_rd_ctrl_rdy", dma_read_ctrl_ready, 1'b0);
      chk("rst_wr_chnl_rdy", dma_write_chnl_ready, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      cyc();
      rst = 1'b1;

      // Long streaming read, ready held high
      rd_req(32'd0, 7880);
      first = 0; last = 0; nv = 0;
      for (int m = 1; m <= 7883; m++) begin
         @(negedge clk);
         if (m == 1) begin
            chk("t1_first_mem_en", mem_en, 1'b1);
            chk("t1_first_mem_we", mem_we, 1'b0);
            chk("t1_first_addr", mem_addr, 16'd0);
         end
         if (dma_read_chnl_valid) begin
            nv++;
            if (first == 0) first = m;
            last = m;
         end
         if (m == 7882) chk("t1_busy_last", busy, 1'b1);
         if (m == 7883) chk("t1_busy_after", busy, 1'b0);
      end
      chk("t1_first_valid", 64'(first), 64'd3);
      chk("t1_last_valid", 64'(last), 64'd7882);
      chk("t1_valid_cycles", 64'(nv), 64'd7880);
      wait_idle(10, "t1_idle");

      // Random backpressure
      p0 = n_pop;
      rnd_rdy = 1'b1;
      rd_req(32'd10000, 128);
      wait_idle(3000, "t2_idle");
      rnd_rdy = 1'b0;
      chk("t2_pops", 64'(n_pop - p0), 64'd128);

      // Beats outside WR_RUN are refused
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data  = 64'hDEAD_BEEF_0000_0001;
      repeat (3) begin
         @(negedge clk);
         chk("idle_wr_chnl_rdy", dma_write_chnl_ready, 1'b0);
         chk("idle_mem_en", mem_en, 1'b0);
         cyc();
      end
      dma_write_chnl_valid = 1'b0;

      // Write with valid every other cycle
      w0 = n_wr;
      wr_req(32'd10128, 249);
      wr_beats(32'd10128, 249, 1);
      wait_idle(20, "t3_idle");
      chk("t3_nwrites", 64'(n_wr - w0), 64'd249);
      bad = 0;
      for (int i = 10128; i <= 10376; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("t3_mem", 64'(bad), 64'd0);

      // Simultaneous read and write requests
      for (int i = 0; i < 5; i++) rd_exp.push_back(ref_mem[20000 + i]);
      dma_read_ctrl_valid        = 1'b1;
      dma_read_ctrl_data_index   = 32'd20000;
      dma_read_ctrl_data_length  = 32'd5;
      dma_write_ctrl_valid       = 1'b1;
      dma_write_ctrl_data_index  = 32'd20100;
      dma_write_ctrl_data_length = 32'd2;
      @(negedge clk);
      chk("t4_rd_rdy", dma_read_ctrl_ready, 1'b1);
      chk("t4_wr_rdy_blocked", dma_write_ctrl_ready, 1'b0);
      cyc();
      dma_read_ctrl_valid = 1'b0;
      blocked = 0; ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (busy) begin
            if (dma_write_ctrl_ready) blocked++;
         end else begin
            ok = 1'b1;
            break;
         end
      end
      chk("t4_wr_held_off", 64'(blocked), 64'd0);
      chk("t4_rd_done", ok, 1'b1);
      chk("t4_rd_left", 64'(rd_exp.size()), 64'd0);
      chk("t4_wr_rdy", dma_write_ctrl_ready, 1'b1);
      cyc();
      dma_write_ctrl_valid = 1'b0;
      wr_beats(32'd20100, 2, 0);
      wait_idle(20, "t4_idle");
      chk("t4_mem0", mem[20100], ref_mem[20100]);
      chk("t4_mem1", mem[20101], ref_mem[20101]);

      // Zero-length read, then wrapping read
      p0 = n_pop;
      rd_req(32'd0, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t5_len0_busy", busy, 1'b0);
         chk("t5_len0_vld", dma_read_chnl_valid, 1'b0);
      end
      chk("t5_len0_pops", 64'(n_pop - p0), 64'd0);
      cyc();
      p0 = n_pop;
      rd_req(32'h0001_FFFE, 4);
      wait_idle(50, "t5_wrap_idle");
      chk("t5_wrap_pops", 64'(n_pop - p0), 64'd4);

      // Reset in the middle of a read
      p0 = n_pop;
      rd_req(32'd0, 50);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (n_pop - p0 >= 10) begin ok = 1'b1; break; end
      end
      chk("t6_ten_beats", ok, 1'b1);
      cyc();
      rst = 1'b0;
      cyc();
      @(negedge clk);
      chk("t6_rst_vld", dma_read_chnl_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_dat", dma_read_chnl_data, 64'd0);
      chk("t6_rst_mem_en", mem_en, 1'b0);
      rd_exp.delete();
      cyc();
      rst = 1'b1;
      cyc();
      p0 = n_pop;
      rd_req(32'd300, 3);
      wait_idle(50, "t6_after_idle");
      chk("t6_after_pops", 64'(n_pop - p0), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
